sd_frame_scheduler: RTL
=======================

SD_FRAME_SCHEDULER -- requirements
Module: sd_frame_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sets the per-component sample width.
REQ-002 SHALL have parameter TIMEOUT, default 1023, sets the maximum cycles to wait for core_done.
REQ-003 SHALL have port Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 SHALL have port in_ready  output  1  upstream beat accepted when in_valid&in_ready.
REQ-007 SHALL have port in_is_channel  input  1  1 = channel (R) beat, 0 = received-vector beat.
REQ-008 SHALL have port in_data  input  WIDTH*8  beat payload.
REQ-009 SHALL have port core_data  output  WIDTH*8  registered copy of the accepted payload.
REQ-010 SHALL have port core_ch_we  output  1  one-cycle channel-beat write strobe.
REQ-011 SHALL have port core_ch_beat  output  2  channel beat index 0..2.
REQ-012 SHALL have port core_y_we  output  1  one-cycle vector write strobe.
REQ-013 SHALL have port core_start  output  1  one-cycle decode start pulse.
REQ-014 SHALL have port core_done  input  1  decode complete, one-cycle pulse.
REQ-015 SHALL have port core_result  input  12  four 3-bit symbol indices, valid with core_done.
REQ-016 SHALL have port out_valid  output  1  result available.
REQ-017 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-018 SHALL have port out_data  output  12  head-of-queue result.
REQ-019 SHALL have port ch_valid  output  1  complete channel loaded.
REQ-020 SHALL have port vec_count  output  16  vectors decoded since the last channel completed.
REQ-021 SHALL have port err_proto  output  1  sticky protocol error.
REQ-022 SHALL have port err_timeout  output  1  sticky decoder timeout.

Function
REQ-023 SHALL implement states NO_CH, CH_LD, IDLE and BUSY.
REQ-024 SHALL register core_data, core_ch_beat, core_ch_we, core_y_we and core_start, so they appear in cycle t+1 for an acceptance in cycle t; the strobes are single-cycle.
REQ-025 SHALL drive in_ready as follows: NO_CH=1, CH_LD=1, IDLE=(result FIFO count<2), BUSY=0.
REQ-026 In NO_CH, an accepted channel beat SHALL issue core_ch_we with beat 0, set beat counter=1 and go to CH_LD.
REQ-027 In NO_CH, an accepted data beat SHALL be dropped with no strobe, set err_proto and stay in NO_CH.
REQ-028 In CH_LD, an accepted channel beat SHALL issue core_ch_we with beat=counter; on counter==2 it SHALL set ch_valid=1, clear vec_count and go to IDLE, otherwise it SHALL increment the counter.
REQ-029 In CH_LD, an accepted data beat SHALL be dropped, set err_proto, clear the counter and go to NO_CH.
REQ-030 In IDLE, an accepted channel beat SHALL clear ch_valid, issue beat 0, set counter=1 and go to CH_LD.
REQ-031 In IDLE, an accepted data beat SHALL issue core_y_we and core_start in the same cycle, clear the watchdog and go to BUSY.
REQ-032 In BUSY, core_done SHALL push core_result into the FIFO, increment vec_count (saturating at 65535) and go to IDLE.
REQ-033 In BUSY without core_done, the watchdog SHALL increment; on reaching TIMEOUT it SHALL set err_timeout, push nothing and go to IDLE.
REQ-034 core_done in the same cycle as watchdog==TIMEOUT SHALL be treated as done, leaving err_timeout unchanged.
REQ-035 core_done outside BUSY SHALL be ignored and SHALL set err_proto.
REQ-036 SHALL implement a 2-entry FIFO with out_valid=(count>0) and out_data=head, popped on out_valid&out_ready.
REQ-037 A simultaneous push and pop SHALL keep count unchanged and preserve order; a push never meets a full FIFO because IDLE gating guarantees room.
REQ-038 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-039 Latency: core_done in cycle d with the FIFO empty SHALL give out_valid=1 in cycle d+1.

Reset
REQ-040 Reset low SHALL immediately force state NO_CH, all counters to 0, the FIFO empty and every output 0, including in_ready.
REQ-041 Reset asserted mid-load or mid-decode SHALL abandon the operation; no strobe SHALL be issued after release until a new acceptance.
REQ-042 err_proto and err_timeout SHALL clear only on reset.

Verification
REQ-043 Send 3 channel beats, then 1 data beat -> core_ch_beat 0,1,2 strobed; ch_valid=1; core_start one cycle after the data acceptance.
REQ-044 Send a data beat first -> no strobe; err_proto=1; state remains NO_CH.
REQ-045 Send core_done with result 12'hA53 and out_ready=0 -> out_valid=1, out_data=12'hA53 held; vec_count=1.
REQ-046 Fill the FIFO with 2 results and hold out_ready=0 -> in_ready=0 in IDLE; popping one entry -> in_ready=1.
REQ-047 Withhold core_done for TIMEOUT cycles -> err_timeout=1, state IDLE, FIFO unchanged.
REQ-048 Assert Reset during CH_LD at beat 1 -> all outputs 0 asynchronously; the next channel beat after release uses beat 0.

Source files
------------

// File: rtl/sd_frame_scheduler_if.sv
// Upstream beat, decoder-core and result-stream signals of sd_frame_scheduler.
// The scheduler takes the slave side and the surrounding logic takes the master side.
interface sd_frame_scheduler_if #(
  parameter int unsigned WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_is_channel;
  logic [WIDTH*8-1:0] in_data;
  logic [WIDTH*8-1:0] core_data;
  logic               core_ch_we;
  logic [1:0]         core_ch_beat;
  logic               core_y_we;
  logic               core_start;
  logic               core_done;
  logic [11:0]        core_result;
  logic               out_valid;
  logic               out_ready;
  logic [11:0]        out_data;

  modport slave (
    input  in_valid, in_is_channel, in_data, core_done, core_result, out_ready,
    output in_ready, core_data, core_ch_we, core_ch_beat, core_y_we, core_start,
    output out_valid, out_data
  );

  modport master (
    output in_valid, in_is_channel, in_data, core_done, core_result, out_ready,
    input  in_ready, core_data, core_ch_we, core_ch_beat, core_y_we, core_start,
    input  out_valid, out_data
  );
endinterface

// File: rtl/sd_frame_scheduler.sv
// Sequences channel loads and vector decodes into a sphere-decoder core, guards the
// core with a watchdog and buffers results in a 2-entry FIFO.
module sd_frame_scheduler #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                        Clk,
  input  logic                        Reset,
  sd_frame_scheduler_if.slave         bus,
  output logic                        ch_valid,
  output logic [15:0]                 vec_count,
  output logic                        err_proto,
  output logic                        err_timeout
);
  localparam int unsigned DW  = WIDTH * 8;
  localparam int unsigned WdW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StNoCh, StChLd, StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  logic             ch_valid_q, ch_valid_d;
  logic [15:0]      vec_q, vec_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic             err_proto_q, err_proto_d;
  logic             err_to_q, err_to_d;
  logic [DW-1:0]    core_data_q, core_data_d;
  logic             ch_we_q, ch_we_d;
  logic [1:0]       ch_beat_q, ch_beat_d;
  logic             y_we_q, y_we_d;
  logic             start_q, start_d;
  logic [11:0]      mem_q [2];
  logic [11:0]      mem_d [2];
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;

  logic in_ready, accept, push, pop, wd_expired;

  assign accept     = bus.in_valid & in_ready;
  assign wd_expired = (wdog_q == WdW'(TIMEOUT));
  assign push       = (state_q == StBusy) & bus.core_done;
  assign pop        = (cnt_q != 2'd0) & bus.out_ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= StNoCh;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StNoCh: if (accept && bus.in_is_channel) state_d = StChLd;
      StChLd: begin
        if (accept) begin
          if (!bus.in_is_channel)  state_d = StNoCh;
          else if (beat_q == 2'd2) state_d = StIdle;
        end
      end
      StIdle: if (accept) state_d = bus.in_is_channel ? StChLd : StBusy;
      StBusy: if (bus.core_done || wd_expired) state_d = StIdle;
      default: state_d = StNoCh;
    endcase
  end

  always_comb begin
    // Gated by Reset so in_ready reads 0 while reset is held, even though NO_CH accepts.
    unique case (state_q)
      StNoCh, StChLd: in_ready = Reset;
      StIdle:         in_ready = Reset & (cnt_q < 2'd2);
      default:        in_ready = 1'b0;
    endcase

    beat_d      = beat_q;
    ch_valid_d  = ch_valid_q;
    vec_d       = vec_q;
    wdog_d      = wdog_q;
    err_proto_d = err_proto_q;
    err_to_d    = err_to_q;
    core_data_d = accept ? bus.in_data : core_data_q;
    ch_we_d     = 1'b0;
    ch_beat_d   = ch_beat_q;
    y_we_d      = 1'b0;
    start_d     = 1'b0;

    unique case (state_q)
      StNoCh: begin
        if (accept) begin
          if (bus.in_is_channel) begin
            ch_we_d   = 1'b1;
            ch_beat_d = 2'd0;
            beat_d    = 2'd1;
          end else begin
            err_proto_d = 1'b1;
          end
        end
      end
      StChLd: begin
        if (accept) begin
          if (bus.in_is_channel) begin
            ch_we_d   = 1'b1;
            ch_beat_d = beat_q;
            if (beat_q == 2'd2) begin
              ch_valid_d = 1'b1;
              vec_d      = 16'd0;
              beat_d     = 2'd0;
            end else begin
              beat_d = beat_q + 2'd1;
            end
          end else begin
            err_proto_d = 1'b1;
            beat_d      = 2'd0;
          end
        end
      end
      StIdle: begin
        if (accept) begin
          if (bus.in_is_channel) begin
            ch_valid_d = 1'b0;
            ch_we_d    = 1'b1;
            ch_beat_d  = 2'd0;
            beat_d     = 2'd1;
          end else begin
            y_we_d  = 1'b1;
            start_d = 1'b1;
            wdog_d  = '0;
          end
        end
      end
      StBusy: begin
        if (bus.core_done) begin
          if (vec_q != 16'hFFFF) vec_d = vec_q + 16'd1;
        end else if (wd_expired) begin
          err_to_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      default: ;
    endcase

    if (bus.core_done && state_q != StBusy) err_proto_d = 1'b1;

    mem_d = mem_q;
    if (push) mem_d[rd_q ^ cnt_q[0]] = bus.core_result;
    rd_d  = pop ? ~rd_q : rd_q;
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      beat_q      <= 2'd0;
      ch_valid_q  <= 1'b0;
      vec_q       <= 16'd0;
      wdog_q      <= '0;
      err_proto_q <= 1'b0;
      err_to_q    <= 1'b0;
      core_data_q <= '0;
      ch_we_q     <= 1'b0;
      ch_beat_q   <= 2'd0;
      y_we_q      <= 1'b0;
      start_q     <= 1'b0;
      mem_q[0]    <= 12'd0;
      mem_q[1]    <= 12'd0;
      rd_q        <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      beat_q      <= beat_d;
      ch_valid_q  <= ch_valid_d;
      vec_q       <= vec_d;
      wdog_q      <= wdog_d;
      err_proto_q <= err_proto_d;
      err_to_q    <= err_to_d;
      core_data_q <= core_data_d;
      ch_we_q     <= ch_we_d;
      ch_beat_q   <= ch_beat_d;
      y_we_q      <= y_we_d;
      start_q     <= start_d;
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.core_data    = core_data_q;
  assign bus.core_ch_we   = ch_we_q;
  assign bus.core_ch_beat = ch_beat_q;
  assign bus.core_y_we    = y_we_q;
  assign bus.core_start   = start_q;
  assign bus.out_valid    = (cnt_q != 2'd0);
  assign bus.out_data     = mem_q[rd_q];
  assign ch_valid         = ch_valid_q;
  assign vec_count        = vec_q;
  assign err_proto        = err_proto_q;
  assign err_timeout      = err_to_q;
endmodule
